// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubbling, capture bypass
// and EX-stage operand forwarding/selection feeding the ALU.
module id_ex_stage #(
   parameter int REG_ADDR_W = 5,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  Stall,
   input  logic                  Flush,
   input  logic                  ID_Valid,
   input  logic [4:0]            ID_ALUCode,
   input  logic                  ID_ALUSrcA,
   input  logic                  ID_ALUSrcB,
   input  logic                  ID_SignExt,
   input  logic [REG_ADDR_W-1:0] ID_Rs,
   input  logic [REG_ADDR_W-1:0] ID_Rt,
   input  logic [REG_ADDR_W-1:0] ID_WriteReg,
   input  logic [DATA_W-1:0]     ID_RsData,
   input  logic [DATA_W-1:0]     ID_RtData,
   input  logic [4:0]            ID_Shamt,
   input  logic [15:0]           ID_Imm16,
   input  logic                  ID_RegWrite,
   input  logic                  ID_MemRead,
   input  logic                  ID_MemWrite,
   input  logic                  ID_MemtoReg,
   input  logic                  MEM_RegWrite,
   input  logic [REG_ADDR_W-1:0] MEM_WriteReg,
   input  logic [DATA_W-1:0]     MEM_ALUResult,
   input  logic                  WB_RegWrite,
   input  logic [REG_ADDR_W-1:0] WB_WriteReg,
   input  logic [DATA_W-1:0]     WB_WriteData,
   output logic [4:0]            ALUCode,
   output logic [DATA_W-1:0]     ALU_A,
   output logic [DATA_W-1:0]     ALU_B,
   output logic [DATA_W-1:0]     EX_StoreData,
   output logic [REG_ADDR_W-1:0] EX_WriteReg,
   output logic                  EX_RegWrite,
   output logic                  EX_MemRead,
   output logic                  EX_MemWrite,
   output logic                  EX_MemtoReg,
   output logic                  EX_Valid,
   output logic                  LoadUseHazard
);
   typedef struct packed {
      logic                  valid;
      logic [4:0]            alu_code;
      logic                  src_a;
      logic                  src_b;
      logic                  sign_ext;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
      logic [REG_ADDR_W-1:0] wr;
      logic [DATA_W-1:0]     rs_d;
      logic [DATA_W-1:0]     rt_d;
      logic [4:0]            shamt;
      logic [15:0]           imm;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
      logic                  mem_to_reg;
   } ex_t;

   ex_t q, cap;
   logic wb_rs, wb_rt;
   logic [DATA_W-1:0] fwd_rs, fwd_rt, imm_ext;

   // WB writes the register file on the same edge we read it; take its data directly
   assign wb_rs = WB_RegWrite && WB_WriteReg != '0 && WB_WriteReg == ID_Rs;
   assign wb_rt = WB_RegWrite && WB_WriteReg != '0 && WB_WriteReg == ID_Rt;

   always_comb begin
      cap = '{valid: ID_Valid, alu_code: ID_ALUCode, src_a: ID_ALUSrcA, src_b: ID_ALUSrcB,
              sign_ext: ID_SignExt, rs: ID_Rs, rt: ID_Rt, wr: ID_WriteReg,
              rs_d: wb_rs ? WB_WriteData : ID_RsData, rt_d: wb_rt ? WB_WriteData : ID_RtData,
              shamt: ID_Shamt, imm: ID_Imm16, reg_write: ID_RegWrite, mem_read: ID_MemRead,
              mem_write: ID_MemWrite, mem_to_reg: ID_MemtoReg};
   end

   assign LoadUseHazard = q.valid && q.mem_read && q.wr != '0 &&
                          (q.wr == ID_Rs || q.wr == ID_Rt) && ID_Valid;

   // A bubble is the all-zero record: invalid, no control, ALUCode = add
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (Flush || (!Stall && LoadUseHazard)) q <= '0;
      else if (!Stall) q <= cap;

   assign fwd_rs = (q.rs == '0) ? '0 :
                   (MEM_RegWrite && MEM_WriteReg == q.rs) ? MEM_ALUResult :
                   (WB_RegWrite && WB_WriteReg == q.rs) ? WB_WriteData : q.rs_d;
   assign fwd_rt = (q.rt == '0) ? '0 :
                   (MEM_RegWrite && MEM_WriteReg == q.rt) ? MEM_ALUResult :
                   (WB_RegWrite && WB_WriteReg == q.rt) ? WB_WriteData : q.rt_d;
   assign imm_ext = {{(DATA_W-16){q.sign_ext & q.imm[15]}}, q.imm};

   assign ALUCode      = q.alu_code;
   assign ALU_A        = q.src_a ? {{(DATA_W-5){1'b0}}, q.shamt} : fwd_rs;
   assign ALU_B        = q.src_b ? imm_ext : fwd_rt;
   assign EX_StoreData = fwd_rt;
   assign EX_WriteReg  = q.wr;
   assign EX_RegWrite  = q.reg_write;
   assign EX_MemRead   = q.mem_read;
   assign EX_MemWrite  = q.mem_write;
   assign EX_MemtoReg  = q.mem_to_reg;
   assign EX_Valid     = q.valid;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-stage operand selection for the 5-stage MIPS core; sits directly upstream of the ALU and drives its ALUCode, A and B inputs.
- Latches decoded instruction fields from ID.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB results.
- Detects load-use hazards and inserts bubbles.

Parameters:
- REG_ADDR_W, 5, register-file index width
- DATA_W, 32, datapath width

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- Stall  input  1  downstream hold; freezes this register
- Flush  input  1  kill the instruction entering EX (wrong path)
- ID_Valid  input  1  ID holds a real instruction
- ID_ALUCode  input  5  ALU operation code, same encoding the ALU consumes
- ID_ALUSrcA  input  1  1: A = zero-extended shamt (sll/srl/sra)
- ID_ALUSrcB  input  1  1: B = extended immediate
- ID_SignExt  input  1  1: sign-extend imm16; 0: zero-extend (andi/xori/ori)
- ID_Rs, ID_Rt, ID_WriteReg  input  5 each  source and destination indices
- ID_RsData, ID_RtData  input  32 each  register-file read data
- ID_Shamt  input  5  shift amount
- ID_Imm16  input  16  immediate
- ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg  input  1 each  control bits
- MEM_RegWrite  input  1  EX/MEM forwarding source: write enable
- MEM_WriteReg  input  5  EX/MEM forwarding source: destination index
- MEM_ALUResult  input  32  EX/MEM forwarding source: result
- WB_RegWrite  input  1  MEM/WB forwarding source: write enable
- WB_WriteReg  input  5  MEM/WB forwarding source: destination index
- WB_WriteData  input  32  MEM/WB forwarding source: write data
- ALUCode  output  5  to ALU
- ALU_A  output  32  to ALU
- ALU_B  output  32  to ALU
- EX_StoreData  output  32  forwarded Rt value for sw
- EX_WriteReg  output  5  registered destination index
- EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg  output  1 each  registered control
- EX_Valid  output  1  registered valid
- LoadUseHazard  output  1  to hazard unit: hold PC and IF/ID this cycle

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registered fields cleared; EX_Valid = 0; ALUCode = 5'b00000 (add).
  - All control outputs 0; ALU_A = ALU_B = EX_StoreData = 0 (no forwarding matches with WriteReg = 0).
- LoadUseHazard (combinational) = EX_Valid & EX_MemRead & EX_WriteReg != 0 & (EX_WriteReg == ID_Rs | EX_WriteReg == ID_Rt) & ID_Valid.
- Per rising edge, priority order:
  1. Flush: bubble (Valid and all control bits 0, ALUCode = add, data fields don't-care but deterministic).
  2. Stall: hold all registers.
  3. LoadUseHazard: bubble.
  4. Otherwise capture ID fields.
  - Flush during Stall still bubbles.
- Capture bypass: when capturing, if WB_RegWrite, WB_WriteReg != 0 and WB_WriteReg == ID_Rs, latch WB_WriteData instead of ID_RsData. Same rule for Rt. This covers the register-file write/read in the same cycle.
- Forwarding (combinational on registered Rs/Rt):
  - Priority MEM over WB over register.
  - MEM hit: MEM_RegWrite & MEM_WriteReg != 0 & MEM_WriteReg == EX_Rs.
  - WB hit: same form, using the WB ports.
  - Register $0 is never forwarded; it always reads 0.
- Operand selection:
  - ALU_A = ID_ALUSrcA(reg) ? {27'b0, Shamt} : fwdRs.
  - ALU_B = ID_ALUSrcB(reg) ? ext(Imm16) : fwdRt.
  - ext: SignExt ? {16{Imm16[15]}, Imm16} : {16'b0, Imm16}.
  - EX_StoreData = fwdRt, unaffected by ALUSrcB.
- Latency: one cycle from ID capture to ALU operands; forwarding adds no cycles.
- Overflow and results are not consumed here.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle -> all outputs 0 immediately; EX_Valid = 0, ALUCode = 0.
- Back-to-back add: instr1 writes $8; EX holds instr2 (rs = $8) while MEM_RegWrite = 1, MEM_WriteReg = 8, MEM_ALUResult = 32'h0000_0064 -> ALU_A = 32'h64. With a simultaneous WB hit on $8 carrying 32'h1 -> ALU_A is still 32'h64.
- Load-use: EX holds lw writing $9 with MemRead = 1; ID instr has rt = $9 -> LoadUseHazard = 1; next edge EX_Valid = 0 and EX_RegWrite = 0; the ID instruction is captured on the following edge.
- Immediates:
  - ori with Imm16 = 16'h8001, SignExt = 0 -> ALU_B = 32'h0000_8001.
  - addi, same Imm16, SignExt = 1 -> ALU_B = 32'hFFFF_8001.
  - sra with Shamt = 31, ALUSrcA = 1 -> ALU_A = 32'd31.
- Stall vs Flush:
  - Stall = 1 for 3 cycles -> all outputs unchanged.
  - Stall = 1 and Flush = 1 together -> bubble on the next edge.
- $0 and capture bypass:
  - MEM_WriteReg = 0 with RegWrite = 1 and EX_Rs = 0 -> ALU_A = 0.
  - WB writes $5 = 32'hDEAD_BEEF on the same edge ID reads $5 -> EX_StoreData = 32'hDEAD_BEEF after capture.
